clk_set_ctrl: RTL and testbench
===============================

# clk_set_ctrl

Time-setting controller for the digital clock. It receives the one-cycle short-press and long-press pulses that the push-button interface generates for the MODE and INC keys. It sequences the set-time state machine and holds a shadow copy of hour, minute and second while the user edits it. On commit it issues a one-cycle load strobe to the timekeeping counter and drives a per-field blink mask to the display driver.

## Interface
Parameters:
- TIMEOUT_CYC, default 26'd50_000_000 (10 s at 5 MHz): key-idle cycles allowed in a set state before aborting.
- BLINK_HALF, default 26'd1_250_000: half-period of the blink toggle, in cycles.

Ports:
- sysclk  in  1  system clock. Reset rst_n, asynchronous, active-low; clock sysclk.
- rst_n  in  1  asynchronous active-low reset.
- mode_sp  in  1  MODE key short-press pulse, one cycle wide.
- mode_lp  in  1  MODE key long-press pulse, one cycle wide.
- inc_sp  in  1  INC key short-press pulse, one cycle wide.
- inc_lp  in  1  INC key long-press pulse, one cycle wide.
- cur_hour  in  5  live hour, 0..23.
- cur_min  in  6  live minute, 0..59.
- cur_sec  in  6  live second, 0..59.
- set_hour  out  5  shadow hour.
- set_min  out  6  shadow minute.
- set_sec  out  6  shadow second.
- load  out  1  one-cycle commit strobe; set_* are valid in the same cycle.
- setting  out  1  high in any state other than RUN; the display shows set_* while high.
- blink_mask  out  3  field currently being edited, {hour, min, sec}, gated by the blink phase.

## Operation
- States: RUN, S_HOUR, S_MIN, S_SEC.
- RUN:
  - mode_lp captures cur_* into set_* and moves to S_HOUR.
  - All other pulses are ignored.
- Set states:
  - mode_sp advances the field: S_HOUR -> S_MIN -> S_SEC -> S_HOUR.
  - mode_lp moves to RUN and pulses load.
  - inc_sp increments the active field, wrapping hour 23->0 and min/sec 59->0.
  - inc_lp clears the active field to 0.
- Priority when pulses coincide: mode_lp > mode_sp > inc_lp > inc_sp. Only one action is taken per cycle; lower-priority pulses in that cycle are dropped.
- Timeout:
  - idle_cnt clears on any key pulse and on entry to S_HOUR, and counts otherwise while in a set state.
  - When idle_cnt reaches TIMEOUT_CYC-1, the block returns to RUN with no load, so edits are discarded.
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1; at the top it wraps and blink_ph toggles.
  - blink_ph is forced to 1 and blink_cnt to 0 on entry to S_HOUR and after any inc action, so an edited field is immediately visible.
  - blink_mask = one-hot(active field) & {3{blink_ph}}. In RUN it is 3'b000.
- Field arithmetic is binary. Compare before adding (hour==23 -> 0), so no intermediate value is ever out of range.
- In RUN, set_* hold their last value. The display must not use them while setting is low.

## Timing
- Reset values:
  - State RUN; load, setting, blink_mask = 0.
  - set_hour, set_min, set_sec = 0.
  - idle_cnt, blink_cnt = 0; blink_ph = 1.
- All outputs are registered.
- Entering setting: mode_lp in cycle N gives setting=1 and set_* = cur_* sampled in cycle N, both in cycle N+1.
- Commit: mode_lp in cycle N gives load=1 for cycle N+1 only, with setting=0 in the same cycle N+1.
- Editing: inc_sp/inc_lp in cycle N gives the updated field in cycle N+1.
- A pulse arriving in the same cycle as the timeout terminal count: the key action wins and idle_cnt clears.
- Reset asserted mid-edit returns immediately to RUN with no load.
- Input pulses are assumed to be single-cycle. A pulse held high for k cycles produces k actions, which the bench checks is not relied upon.

## Structure
- Shared include para.v holds:
  - the state encodings as `define: RUN, S_HOUR, S_MIN, S_SEC;
  - `SET_TIMEOUT and `BLINK_HALF defaults;
  - field maxima `HOUR_MAX = 23 and `MINSEC_MAX = 59.
- One sub-module, set_blink_timer, contains idle_cnt, blink_cnt and blink_ph.
  - Inputs: en, kick, restart_blink.
  - Outputs: timeout, blink_ph.
- The FSM and field registers stay in clk_set_ctrl.

## Test plan
- Reset with cur = 12:34:56, then mode_lp: setting=1 next cycle, set = 12:34:56, blink_mask = 3'b100.
- In S_HOUR with set_hour = 23, apply inc_sp: set_hour = 0. Then mode_sp and inc_lp: set_min = 0, blink_mask field = min.
- Edit to 07:59:00, apply inc_sp in S_MIN to get 07:00:00, then mode_lp: exactly one load cycle with set = 07:00:00, then setting = 0.
- mode_sp and inc_sp in the same cycle in S_MIN: state becomes S_SEC and set_min is unchanged. Next, mode_lp and inc_sp together: load with set_sec unchanged.
- TIMEOUT_CYC = 100 with no pulses after entry: at cycle 100 after entry, setting = 0, no load, blink_mask = 0. Repeat with a kick at cycle 99: still in the set state at cycle 100.
- rst_n pulsed low mid-edit while in S_SEC: all outputs reach their reset values asynchronously and no load is seen.

Source files
------------

// File: rtl/clk_set_ctrl_pkg.sv
// Shared types, defaults and field helpers for the time-setting controller.
package clk_set_ctrl_pkg;

  // Width of the idle and blink counters; wide enough for a 10 s timeout at 5 MHz.
  localparam int CNT_W = 26;

  localparam logic [CNT_W-1:0] DEF_TIMEOUT_CYC = 26'd50_000_000;
  localparam logic [CNT_W-1:0] DEF_BLINK_HALF  = 26'd1_250_000;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // Set-time state machine encoding.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_e;

  // The single action taken in a cycle after key priority is resolved.
  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_ENTER   = 3'd1,
    ACT_COMMIT  = 3'd2,
    ACT_ADVANCE = 3'd3,
    ACT_CLEAR   = 3'd4,
    ACT_INC     = 3'd5,
    ACT_ABORT   = 3'd6
  } action_e;

  // One-hot {hour, min, sec} of the field edited in a given state.
  function automatic logic [2:0] field_onehot(input state_e s);
    case (s)
      S_HOUR:  return 3'b100;
      S_MIN:   return 3'b010;
      S_SEC:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Hour increment with wrap; compares before adding so the sum never leaves 0..23.
  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == HOUR_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  // Minute/second increment with wrap at 59.
  function automatic logic [5:0] minsec_inc(input logic [5:0] v);
    return (v == MINSEC_MAX) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clk_set_ctrl_blink_timer.sv
// Idle-timeout counter and blink phase generator used while a field is being set.
module set_blink_timer
  import clk_set_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [CNT_W-1:0] BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic en,            // controller is in a set state
  input  logic kick,          // any key pulse this cycle
  input  logic restart_blink, // force the edited field visible
  output logic timeout,
  output logic blink_ph
);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  // Terminal count is decoded from the register only, so a key in the same cycle still wins.
  assign timeout  = en && (idle_cnt_q == TIMEOUT_CYC - CNT_W'(1));
  assign blink_ph = blink_ph_q;

  // Next-state for the idle and blink counters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idle_cnt_d  = idle_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (!en || kick || restart_blink || timeout) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end

    if (!en || restart_blink) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_HALF - CNT_W'(1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
    end
  end

  // Counter and phase registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    // NOTE: every state register has an explicit reset value; blink_ph resets to 1 (visible).
    if (!rst_n) begin
      idle_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      idle_cnt_q  <= idle_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

endmodule

// File: rtl/clk_set_ctrl.sv
// Time-setting controller: set-state FSM, shadow hour/min/sec and commit strobe.
module clk_set_ctrl
  import clk_set_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [CNT_W-1:0] BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       mode_sp,
  input  logic       mode_lp,
  input  logic       inc_sp,
  input  logic       inc_lp,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       setting,
  output logic [2:0] blink_mask
);

  state_e     state_q, state_d;
  logic [4:0] set_hour_q, set_hour_d;
  logic [5:0] set_min_q, set_min_d;
  logic [5:0] set_sec_q, set_sec_d;
  logic       load_q, load_d;

  action_e    act;
  logic       in_set;
  logic       kick;
  logic       restart_blink;
  logic       timeout;
  logic       blink_ph;

  assign in_set = (state_q != RUN);
  assign kick   = mode_sp | mode_lp | inc_sp | inc_lp;

  // Resolve coincident keys into one action: mode_lp > mode_sp > inc_lp > inc_sp > timeout.
  always_comb begin
    act = ACT_NONE;
    if (!in_set) begin
      if (mode_lp) act = ACT_ENTER;
    end else if (mode_lp) begin
      act = ACT_COMMIT;
    end else if (mode_sp) begin
      act = ACT_ADVANCE;
    end else if (inc_lp) begin
      act = ACT_CLEAR;
    end else if (inc_sp) begin
      act = ACT_INC;
    end else if (timeout) begin
      act = ACT_ABORT;
    end
  end

  // Blink restarts on every entry to S_HOUR and after any field edit.
  assign restart_blink = (act == ACT_ENTER) || (act == ACT_CLEAR) || (act == ACT_INC) ||
                         ((act == ACT_ADVANCE) && (state_q == S_SEC));

  set_blink_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .BLINK_HALF  (BLINK_HALF)
  ) u_timer (
    .sysclk        (sysclk),
    .rst_n         (rst_n),
    .en            (in_set),
    .kick          (kick),
    .restart_blink (restart_blink),
    .timeout       (timeout),
    .blink_ph      (blink_ph)
  );

  // Next state, shadow field updates and commit strobe.
  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    load_d     = 1'b0;

    case (act)
      ACT_ENTER: begin
        state_d    = S_HOUR;
        set_hour_d = cur_hour;
        set_min_d  = cur_min;
        set_sec_d  = cur_sec;
      end
      ACT_COMMIT: begin
        state_d = RUN;
        load_d  = 1'b1;
      end
      ACT_ABORT: begin
        state_d = RUN;
      end
      ACT_ADVANCE: begin
        case (state_q)
          S_HOUR:  state_d = S_MIN;
          S_MIN:   state_d = S_SEC;
          default: state_d = S_HOUR;
        endcase
      end
      ACT_CLEAR: begin
        case (state_q)
          S_HOUR:  set_hour_d = 5'd0;
          S_MIN:   set_min_d  = 6'd0;
          default: set_sec_d  = 6'd0;
        endcase
      end
      ACT_INC: begin
        case (state_q)
          S_HOUR:  set_hour_d = hour_inc(set_hour_q);
          S_MIN:   set_min_d  = minsec_inc(set_min_q);
          default: set_sec_d  = minsec_inc(set_sec_q);
        endcase
      end
      default: begin
      end
    endcase
  end

  // State, shadow field and strobe registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      set_hour_q <= 5'd0;
      set_min_q  <= 6'd0;
      set_sec_q  <= 6'd0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      load_q     <= load_d;
    end
  end

  // setting and blink_mask decode flop outputs only; no input reaches them combinationally.
  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;
  assign load       = load_q;
  assign setting    = in_set;
  assign blink_mask = field_onehot(state_q) & {3{blink_ph}};

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Directed scoreboard bench for clk_set_ctrl with a short timeout and blink period.
module tb_clk_set_ctrl;

  localparam logic [25:0] TB_TIMEOUT = 26'd100;
  localparam logic [25:0] TB_BLINK   = 26'd20;

  logic       sysclk;
  logic       rst_n;
  logic       mode_sp, mode_lp, inc_sp, inc_lp;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load, setting;
  logic [2:0] blink_mask;

  typedef struct {
    string      tag;
    logic       setting;
    logic       load;
    logic [2:0] mask;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   load_cnt = 0;
  int   load_base;

  clk_set_ctrl #(
    .TIMEOUT_CYC (TB_TIMEOUT),
    .BLINK_HALF  (TB_BLINK)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .mode_sp    (mode_sp),
    .mode_lp    (mode_lp),
    .inc_sp     (inc_sp),
    .inc_lp     (inc_lp),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .load       (load),
    .setting    (setting),
    .blink_mask (blink_mask)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Count every load cycle seen, sampled away from the active edge.
  always @(negedge sysclk) if (load === 1'b1) load_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic st, input logic ld,
                            input logic [2:0] mk, input logic [4:0] h,
                            input logic [5:0] m, input logic [5:0] s);
    exp_t e;
    e.tag = tag; e.setting = st; e.load = ld; e.mask = mk;
    e.hour = h; e.min = m; e.sec = s;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".setting"}, 32'(setting),    32'(e.setting));
      check({e.tag, ".load"},    32'(load),       32'(e.load));
      check({e.tag, ".mask"},    32'(blink_mask), 32'(e.mask));
      check({e.tag, ".hour"},    32'(set_hour),   32'(e.hour));
      check({e.tag, ".min"},     32'(set_min),    32'(e.min));
      check({e.tag, ".sec"},     32'(set_sec),    32'(e.sec));
    end
  endtask

  // Drive keys {mode_lp, mode_sp, inc_lp, inc_sp} for one cycle, check the following cycle.
  task automatic pulse(input logic [3:0] keys, input string tag, input logic st,
                       input logic ld, input logic [2:0] mk, input logic [4:0] h,
                       input logic [5:0] m, input logic [5:0] s);
    @(negedge sysclk);
    {mode_lp, mode_sp, inc_lp, inc_sp} = keys;
    expect_out(tag, st, ld, mk, h, m, s);
    @(negedge sysclk);
    {mode_lp, mode_sp, inc_lp, inc_sp} = 4'b0000;
    check_out();
  endtask

  task automatic sample(input string tag, input logic st, input logic ld,
                        input logic [2:0] mk, input logic [4:0] h,
                        input logic [5:0] m, input logic [5:0] s);
    expect_out(tag, st, ld, mk, h, m, s);
    check_out();
  endtask

  task automatic idle_to(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    rst_n = 1'b0;
    {mode_lp, mode_sp, inc_lp, inc_sp} = 4'b0000;
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    #22;
    sample("reset", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);
    @(negedge sysclk);
    rst_n = 1'b1;

    // Entry captures the live time; then watch the first blink toggle.
    pulse(4'b1000, "enter", 1'b1, 1'b0, 3'b100, 5'd12, 6'd34, 6'd56);
    idle_to(19);
    sample("blink_on", 1'b1, 1'b0, 3'b100, 5'd12, 6'd34, 6'd56);
    idle_to(1);
    sample("blink_off", 1'b1, 1'b0, 3'b000, 5'd12, 6'd34, 6'd56);

    // Hour up to 23, then wrap to 0.
    for (int i = 1; i <= 11; i++)
      pulse(4'b0001, "inc_hour", 1'b1, 1'b0, 3'b100, 5'(12 + i), 6'd34, 6'd56);
    pulse(4'b0001, "hour_wrap", 1'b1, 1'b0, 3'b100, 5'd0, 6'd34, 6'd56);
    pulse(4'b0100, "adv_min", 1'b1, 1'b0, 3'b010, 5'd0, 6'd34, 6'd56);
    pulse(4'b0010, "clr_min", 1'b1, 1'b0, 3'b010, 5'd0, 6'd0, 6'd56);
    pulse(4'b0100, "adv_sec", 1'b1, 1'b0, 3'b001, 5'd0, 6'd0, 6'd56);
    pulse(4'b0010, "clr_sec", 1'b1, 1'b0, 3'b001, 5'd0, 6'd0, 6'd0);
    pulse(4'b0100, "adv_hour", 1'b1, 1'b0, 3'b100, 5'd0, 6'd0, 6'd0);

    // Build 07:59:00, wrap minutes to 07:00:00 and commit.
    for (int i = 1; i <= 7; i++)
      pulse(4'b0001, "inc7", 1'b1, 1'b0, 3'b100, 5'(i), 6'd0, 6'd0);
    pulse(4'b0100, "adv_min2", 1'b1, 1'b0, 3'b010, 5'd7, 6'd0, 6'd0);
    for (int i = 1; i <= 59; i++)
      pulse(4'b0001, "inc_min", 1'b1, 1'b0, 3'b010, 5'd7, 6'(i), 6'd0);
    pulse(4'b0001, "min_wrap", 1'b1, 1'b0, 3'b010, 5'd7, 6'd0, 6'd0);
    load_base = load_cnt;
    pulse(4'b1000, "commit", 1'b0, 1'b1, 3'b000, 5'd7, 6'd0, 6'd0);
    idle_to(1);
    sample("commit_once", 1'b0, 1'b0, 3'b000, 5'd7, 6'd0, 6'd0);
    check("commit_load_count", 32'(load_cnt - load_base), 32'd1);

    // Coincident pulses: the higher-priority key wins, the other is dropped.
    pulse(4'b1000, "reenter", 1'b1, 1'b0, 3'b100, 5'd12, 6'd34, 6'd56);
    pulse(4'b0100, "adv_min3", 1'b1, 1'b0, 3'b010, 5'd12, 6'd34, 6'd56);
    pulse(4'b0101, "msp_isp", 1'b1, 1'b0, 3'b001, 5'd12, 6'd34, 6'd56);
    pulse(4'b1001, "mlp_isp", 1'b0, 1'b1, 3'b000, 5'd12, 6'd34, 6'd56);
    idle_to(1);
    sample("mlp_isp_after", 1'b0, 1'b0, 3'b000, 5'd12, 6'd34, 6'd56);

    // Timeout with no keys: abort at cycle 100 after entry, edits discarded, no load.
    cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    load_base = load_cnt;
    pulse(4'b1000, "to_enter", 1'b1, 1'b0, 3'b100, 5'd1, 6'd2, 6'd3);
    idle_to(99);
    sample("to_pre", 1'b1, 1'b0, 3'b100, 5'd1, 6'd2, 6'd3);
    idle_to(1);
    sample("to_abort", 1'b0, 1'b0, 3'b000, 5'd1, 6'd2, 6'd3);
    idle_to(1);
    sample("to_after", 1'b0, 1'b0, 3'b000, 5'd1, 6'd2, 6'd3);
    check("to_no_load", 32'(load_cnt - load_base), 32'd0);

    // A key on the terminal-count cycle wins and keeps the controller in setting.
    cur_hour = 5'd20; cur_min = 6'd45; cur_sec = 6'd10;
    pulse(4'b1000, "kick_enter", 1'b1, 1'b0, 3'b100, 5'd20, 6'd45, 6'd10);
    idle_to(98);
    pulse(4'b0001, "kick99", 1'b1, 1'b0, 3'b100, 5'd21, 6'd45, 6'd10);
    pulse(4'b0100, "k_min", 1'b1, 1'b0, 3'b010, 5'd21, 6'd45, 6'd10);
    pulse(4'b0100, "k_sec", 1'b1, 1'b0, 3'b001, 5'd21, 6'd45, 6'd10);
    pulse(4'b0011, "ilp_isp", 1'b1, 1'b0, 3'b001, 5'd21, 6'd45, 6'd0);

    // A pulse held for three cycles yields three increments.
    @(negedge sysclk);
    inc_sp = 1'b1;
    expect_out("held3", 1'b1, 1'b0, 3'b001, 5'd21, 6'd45, 6'd3);
    idle_to(3);
    inc_sp = 1'b0;
    check_out();

    // Asynchronous reset mid-edit in S_SEC.
    load_base = load_cnt;
    @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1 sample("async_rst", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);
    idle_to(2);
    sample("rst_hold", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);
    rst_n = 1'b1;
    idle_to(2);
    sample("post_rst", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);
    check("rst_no_load", 32'(load_cnt - load_base), 32'd0);

    // In RUN, keys other than mode_lp are ignored.
    pulse(4'b0001, "run_isp", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);
    pulse(4'b0100, "run_msp", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);
    pulse(4'b0010, "run_ilp", 1'b0, 1'b0, 3'b000, 5'd0, 6'd0, 6'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200_000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
